// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    EXT,
    WR,
    RSP
  } lsuState_t;

  // The data memory is word addressed, so the byte offset is dropped.
  function automatic logic [31:0] wordIndex(input logic [31:0] byteAddr);
    return {2'b00, byteAddr[31:2]};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] memWord,
  input  logic [1:0]  laneSel,
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic [31:0] mergedData
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane   = memWord[{laneSel, 3'b000} +: 8];
    halfLane   = memWord[{laneSel[1], 4'b0000} +: 16];
    loadData   = memWord;
    mergedData = storeData;
    case (size)
      SZ_BYTE: begin
        loadData = {{24{~isUnsigned & byteLane[7]}}, byteLane};
        mergedData = memWord;
        mergedData[{laneSel, 3'b000} +: 8] = storeData[7:0];
      end
      SZ_HALF: begin
        loadData = {{16{~isUnsigned & halfLane[15]}}, halfLane};
        mergedData = memWord;
        mergedData[{laneSel[1], 4'b0000} +: 16] = storeData[15:0];
      end
      default: begin
        loadData   = memWord;
        mergedData = storeData;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: sequences a registered-read word memory and
// answers each request with exactly one resp_valid pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 301
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_MemWrite_signal,
  output logic        mem_MemRead_signal,
  input  logic [31:0] mem_readData
);

  localparam logic [29:0] MemWordsW = 30'(MEM_WORDS);

  lsuState_t   state, nextState;
  logic        accept, reqErr;
  logic        writeReg, unsignedReg;
  logic [1:0]  sizeReg;
  logic [31:0] addrReg, wdataReg;
  logic [31:0] loadData, mergedData;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  assign reqErr = (req_size == SZ_RSVD)
               || (req_size == SZ_HALF && req_addr[0])
               || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
               || (req_addr[31:2] >= MemWordsW);

  // Enables decode straight from state so an async reset drops them at once.
  assign mem_address         = wordIndex(addrReg);
  assign mem_MemRead_signal  = (state == RD);
  assign mem_MemWrite_signal = (state == WR);
  assign mem_writeData       = (state == WR) ? mergedData : 32'd0;

  lsu_lane_align u_align (
    .memWord    (mem_readData),
    .laneSel    (addrReg[1:0]),
    .size       (sizeReg),
    .isUnsigned (unsignedReg),
    .storeData  (wdataReg),
    .loadData   (loadData),
    .mergedData (mergedData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reqErr)                                nextState = RSP;
          else if (req_write && req_size == SZ_WORD) nextState = WR;
          else                                       nextState = RD;
        end
      end
      RD:      nextState = writeReg ? WR : EXT;
      EXT:     nextState = IDLE;
      WR:      nextState = RSP;
      RSP:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Response is registered: loads pulse in the IDLE after EXT, others during RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeReg    <= 1'b0;
      unsignedReg <= 1'b0;
      sizeReg     <= 2'b00;
      addrReg     <= 32'd0;
      wdataReg    <= 32'd0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      if (accept) begin
        writeReg    <= req_write;
        unsignedReg <= req_unsigned;
        sizeReg     <= req_size;
        addrReg     <= req_addr;
        wdataReg    <= req_wdata;
        if (reqErr) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end
      end
      if (state == EXT) begin
        resp_valid <= 1'b1;
        resp_rdata <= loadData;
      end
      if (state == WR) resp_valid <= 1'b1;
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the MEM-stage control of the 32-bit MIPS datapath and the word-addressed data memory.
- Converts byte addresses to word indices and performs lb/lbu/lh/lhu/lw loads with sign or zero extension.
- Performs sb/sh stores as read-modify-write; performs sw as a single write.
- Sequences the memory's registered (1-cycle) read port with a small FSM and a valid/ready handshake to the pipeline.

Parameters:
- MEM_WORDS, 301, number of 32-bit words in the data memory; word index >= MEM_WORDS is out of range.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse: load data or store completion
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned, reserved size, or out of range
- mem_address  out  32  word index {2'b00, addr[31:2]}
- mem_writeData  out  32  word written to memory
- mem_MemWrite_signal  out  1  memory write enable
- mem_MemRead_signal  out  1  memory read enable
- mem_readData  in  32  memory registered read data; valid the cycle after MemRead was sampled

Behaviour:
- Reset: async on rst_n low. State goes to IDLE. resp_valid, resp_err, resp_rdata, mem_address, mem_writeData all 0. Memory enables deassert immediately. Reset mid-operation aborts the operation; no partial write is issued after release.
- States: IDLE, RD, EXT, WR, RSP.
- req_ready = 1 only in IDLE. Accept = req_valid && req_ready; request fields are captured into registers on that edge.
- Error check at accept. Error if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS. On error: IDLE→RSP; no memory access; resp_err=1, resp_rdata=0.
- Load: IDLE→RD→EXT→IDLE.
  - RD: MemRead=1.
  - EXT: extract from mem_readData, then register resp_rdata with resp_valid=1 on exiting EXT.
  - resp_valid is high 3 cycles after accept, in the following IDLE cycle.
- Store word: IDLE→WR→RSP. WR: MemWrite=1, mem_writeData=wdata.
- Store byte/half: IDLE→RD→WR→RSP. WR: mem_writeData = mem_readData with the selected lane replaced by wdata[7:0] or wdata[15:0]. All other lanes are preserved bit-exactly.
- RSP: resp_valid=1, resp_rdata=0, resp_err as computed → IDLE.
- Lanes are little-endian: byte k = bits [8k+7:8k] with k=addr[1:0]; half h = bits [16h+15:16h] with h=addr[1].
- Extension: signed loads replicate the MSB of the lane; unsigned loads zero-fill.
- Enables: MemRead and MemWrite are never asserted in the same cycle. mem_address is held stable from RD through WR.
- Back-to-back: a new request may be accepted in the same IDLE cycle in which resp_valid of the previous load is high.
- Every request causes exactly one resp_valid pulse.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - helper for word index
- Sub-module lsu_lane_align (combinational):
  - extract + extend for loads
  - merge for sub-word stores
  - reused by both paths

Test Plan:
- sw addr=0x10 wdata=0x8899AABB → WR cycle has MemWrite=1 with address 4; resp_valid, err=0. Then lw 0x10 → resp_rdata=0x8899AABB exactly 3 cycles after accept.
- lb 0x13 → 0xFFFFFF88; lbu 0x13 → 0x00000088; lh 0x12 → 0xFFFF8899; lhu 0x10 → 0x0000AABB.
- sb addr=0x11 wdata=0x55 over 0x8899AABB → memory word 4 = 0x889955BB. Then sh addr=0x12 wdata=0x1234 → 0x123455BB.
- lh 0x11 / lw 0x12 / size=11 / lw addr=301*4 → resp_err=1, resp_rdata=0; no MemRead/MemWrite ever asserted.
- Deassert rst_n during the RD of an sb → state IDLE, enables 0 immediately, no write. After release, the target word is unchanged.
- req_valid held high for 4 consecutive loads → each accepted only when req_ready=1; 4 resp_valid pulses, in order, with correct data.
